huffman_encoder_scheduler: RTL and testbench

- Frame-level arbiter and sequencer that shares one HuffmanEncoder instance among NUM_REQ byte-stream requesters.
- Grants the encoder to one requester for a whole frame of DATA_LENGTH bytes, chosen round-robin.
- Streams the frame into the encoder's inputData/dataEnable, then holds off all requesters until the encoder reports completion.
- Sits between the requester-side stream sources and the encoder.

---
 rtl/huffman_sched_pkg.sv | 29 ++
 rtl/huffman_encoder_scheduler_rr_arbiter.sv | 31 +++
 rtl/huffman_encoder_scheduler.sv | 128 ++++++++++++
 tb/tb_huffman_encoder_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_sched_pkg.sv
// Shared types and helpers for the Huffman encoder frame scheduler.
// Optional feature macro (used by the scheduler): HUFF_SCHED_TIMEOUT_EN.
package huffman_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_ENC = 2'd2
  } sched_state_e;

  localparam int unsigned DEF_BIT_IN_BYTE = 7;
  localparam int unsigned DEF_DATA_LENGTH = 100;

  // Byte width from the encoder's bitInByte (width minus one).
  function automatic int unsigned byte_width(input int unsigned bit_in_byte);
    return bit_in_byte + 1;
  endfunction

  // Counter width able to hold the full frame length.
  function automatic int unsigned count_width(input int unsigned data_length);
    return $clog2(data_length + 1);
  endfunction

  // Low bit of slice idx inside a packed vector of width-bit slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/huffman_encoder_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Rotating priority search starting at ptr.
  always_comb begin
    int unsigned c;
    logic        found;
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = (32'(ptr) + i) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/huffman_encoder_scheduler.sv
// Frame-level arbiter/sequencer sharing one Huffman encoder among NUM_REQ
// byte-stream requesters. Optional watchdog in WAIT_ENC: HUFF_SCHED_TIMEOUT_EN.
module huffman_encoder_scheduler
  import huffman_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BIT_IN_BYTE    = DEF_BIT_IN_BYTE,
  parameter int DATA_LENGTH    = DEF_DATA_LENGTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*(BIT_IN_BYTE+1)-1:0]    req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [BIT_IN_BYTE:0]                  enc_data,
  output logic                                  enc_enable,
  input  logic                                  enc_done,
  output logic [$clog2(NUM_REQ)-1:0]            grant_id,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  timeout_err
);

  localparam int BYTE_W = byte_width(BIT_IN_BYTE);
  localparam int IW     = $clog2(NUM_REQ);
  localparam int CNT_W  = count_width(DATA_LENGTH);

  sched_state_e         state, state_next;
  logic [IW-1:0]        rr_ptr;
  logic [CNT_W-1:0]     byte_cnt;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 accept;
  logic                 last_beat;
  logic                 finish;
  logic                 expire;
  logic [IW-1:0]        next_ptr;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign arb_any   = |arb_grant;
  assign accept    = (state == STREAM) && req_valid[grant_id];
  assign last_beat = accept && (byte_cnt == CNT_W'(DATA_LENGTH - 1));
  assign finish    = (state == WAIT_ENC) && enc_done;
  assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

`ifdef HUFF_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // enc_done on the expiry cycle takes precedence over the watchdog.
  assign expire = (state == WAIT_ENC) && !enc_done && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter (cleared outside WAIT_ENC) and its error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if ((state == WAIT_ENC) && !finish && !expire) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                                           tmo_cnt <= '0;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and req_ready decode (registered state only).
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE:     if (arb_any) state_next = STREAM;
      STREAM: begin
        req_ready[grant_id] = 1'b1;
        if (last_beat) state_next = WAIT_ENC;
      end
      WAIT_ENC: if (finish || expire) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Grant, counters and encoder-side output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_id   <= '0;
      rr_ptr     <= '0;
      byte_cnt   <= '0;
      busy       <= 1'b0;
      enc_data   <= '0;
      enc_enable <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      enc_enable <= accept;
      frame_done <= finish;
      if (accept) begin
        enc_data <= req_data[slice_lo(32'(grant_id), BYTE_W) +: BYTE_W];
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if ((state == IDLE) && arb_any) begin
        grant_id <= arb_idx;
        busy     <= 1'b1;
      end
      if (finish || expire) begin
        rr_ptr   <= next_ptr;
        byte_cnt <= '0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_huffman_encoder_scheduler.sv
// Self-checking bench for huffman_encoder_scheduler (NUM_REQ=3, DATA_LENGTH=4,
// TIMEOUT_CYCLES=16). Honours HUFF_SCHED_TIMEOUT_EN for the watchdog section.
module tb_huffman_encoder_scheduler;

  localparam int NR  = 3;
  localparam int BW  = 8;
  localparam int DL  = 4;
  localparam int TMO = 16;
  localparam int IW  = 2;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*BW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [BW-1:0]     enc_data;
  logic              enc_enable;
  logic              enc_done;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              frame_done;
  logic              timeout_err;

  huffman_encoder_scheduler #(
    .NUM_REQ(NR), .BIT_IN_BYTE(BW-1), .DATA_LENGTH(DL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_data(enc_data), .enc_enable(enc_enable),
    .enc_done(enc_done), .grant_id(grant_id), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NR-1:0] mask;
    int            grant;
    bit            gap;
    bit            stray;
    int            delay;
    logic [NR-1:0] next_mask;
  } vec_t;

  vec_t        tbl [9];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_data;
  int          n_checks;
  int          n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Byte requester r presents for beat b of its frame (requester 1: 0x41..).
  function automatic logic [7:0] beat_byte(input int r, input int b);
    return 8'(8'h41 + 16 * (r - 1) + b);
  endfunction

  task automatic set_slice(input int r, input logic [7:0] v);
    req_data[r*BW +: BW] = v;
  endtask

  // Encoder side: each accepted byte must appear exactly one cycle later.
  task automatic sample();
    logic [7:0] e;
    check("enc_enable", {31'd0, enc_enable}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("enc_data", {24'd0, enc_data}, {24'd0, e});
      last_data = e;
    end else begin
      check("enc_data_hold", {24'd0, enc_data}, {24'd0, last_data});
    end
  endtask

  task automatic tick();
    @(negedge clock);
    sample();
  endtask

  // Arbitrate with mask, expect grant g, then stream n_beats from g.
  task automatic stream_frame(input logic [NR-1:0] mask, input int g, input bit gap,
                              input bit stray, input int n_beats, input logic [NR-1:0] after_mask);
    int            beats;
    int            cyc;
    bit            v;
    logic [NR-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    req_valid = mask;
    for (int r = 0; r < NR; r++) set_slice(r, beat_byte(r, 0));
    tick();
    check("busy_on_grant", {31'd0, busy}, 32'd1);
    check("grant_id", {30'd0, grant_id}, 32'(g));
    check("frame_done_pulse_width", {31'd0, frame_done}, 32'd0);
    beats = 0;
    cyc   = 0;
    while (beats < n_beats && cyc < 40) begin
      check("req_ready_stream", {29'd0, req_ready}, {29'd0, oh});
      check("frame_done_in_stream", {31'd0, frame_done}, 32'd0);
      v = !gap || (cyc % 2 == 0);
      req_valid[g] = v;
      set_slice(g, beat_byte(g, beats));
      enc_done = stray && (cyc == 1);
      if (v) begin
        exp_q.push_back(beat_byte(g, beats));
        beats++;
      end
      cyc++;
      tick();
    end
    enc_done = 1'b0;
    check("accept_cycles", 32'(cyc), gap ? 32'(2 * n_beats - 1) : 32'(n_beats));
    if (beats == DL) check("req_ready_drop", {29'd0, req_ready}, 32'd0);
    req_valid = after_mask;
    for (int r = 0; r < NR; r++) set_slice(r, beat_byte(r, 0));
  endtask

  // Wait delay cycles in WAIT_ENC, then pulse enc_done and check completion.
  task automatic finish_frame(input int delay);
    for (int i = 0; i < delay; i++) begin
      check("busy_wait", {31'd0, busy}, 32'd1);
      check("frame_done_early", {31'd0, frame_done}, 32'd0);
      tick();
    end
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    check("frame_done", {31'd0, frame_done}, 32'd1);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("req_ready_after_done", {29'd0, req_ready}, 32'd0);
    check("beats_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        {31'd0, busy}, 32'd0);
    check({tag, "_grant_id"},    {30'd0, grant_id}, 32'd0);
    check({tag, "_req_ready"},   {29'd0, req_ready}, 32'd0);
    check({tag, "_enc_enable"},  {31'd0, enc_enable}, 32'd0);
    check({tag, "_enc_data"},    {24'd0, enc_data}, 32'd0);
    check({tag, "_frame_done"},  {31'd0, frame_done}, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int k;
    n_checks  = 0;
    n_pass    = 0;
    last_data = 8'h00;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    enc_done  = 1'b0;

    // {mask, grant, gap, stray enc_done, done delay, mask held afterwards}
    tbl[0] = '{3'b111, 0, 1'b0, 1'b0, 0, 3'b111};
    tbl[1] = '{3'b111, 1, 1'b0, 1'b1, 1, 3'b111};
    tbl[2] = '{3'b111, 2, 1'b0, 1'b0, 0, 3'b111};
    tbl[3] = '{3'b111, 0, 1'b0, 1'b0, 3, 3'b000};
    tbl[4] = '{3'b100, 2, 1'b1, 1'b0, 2, 3'b000};
    tbl[5] = '{3'b001, 0, 1'b0, 1'b0, 0, 3'b001};
    tbl[6] = '{3'b001, 0, 1'b0, 1'b0, 1, 3'b000};
    tbl[7] = '{3'b011, 1, 1'b0, 1'b0, 0, 3'b000};
    tbl[8] = '{3'b011, 0, 1'b0, 1'b0, 0, 3'b000};

    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Requester 1 alone: 0x41..0x44.
    stream_frame(3'b010, 1, 1'b0, 1'b0, DL, 3'b000);
    finish_frame(2);

    // Reset mid-STREAM after two bytes from requester 2.
    stream_frame(3'b100, 2, 1'b0, 1'b0, 2, 3'b000);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    req_valid = '0;
    exp_q.delete();
    last_data = 8'h00;
    tick();
    reset = 1'b0;

    // Round-robin sequences; first entry proves rr_ptr/byte_cnt were cleared.
    for (int i = 0; i < 9; i++) begin
      stream_frame(tbl[i].mask, tbl[i].grant, tbl[i].gap, tbl[i].stray, DL, tbl[i].next_mask);
      finish_frame(tbl[i].delay);
    end

    // enc_done while IDLE is ignored.
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    tick();
    check("idle_done_frame_done", {31'd0, frame_done}, 32'd0);
    check("idle_done_busy", {31'd0, busy}, 32'd0);

    // No enc_done: watchdog (if built) or indefinite wait.
    stream_frame(3'b010, 1, 1'b0, 1'b0, DL, 3'b111);
`ifdef HUFF_SCHED_TIMEOUT_EN
    k = 0;
    while (timeout_err !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("timeout_cycles", 32'(k), 32'(TMO));
    check("timeout_no_frame_done", {31'd0, frame_done}, 32'd0);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    tick();
    req_valid = '0;
    check("timeout_err_pulse_width", {31'd0, timeout_err}, 32'd0);
    check("timeout_next_busy", {31'd0, busy}, 32'd1);
    check("timeout_next_grant", {30'd0, grant_id}, 32'd2);
`else
    k = 0;
    repeat (40) begin
      tick();
      k++;
    end
    check("no_tmo_busy", {31'd0, busy}, 32'd1);
    check("no_tmo_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("no_tmo_frame_done", {31'd0, frame_done}, 32'd0);
    req_valid = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
